// File: rtl/cpu_multisim_server_rx.sv
// cpu_multisim_server_rx
//   Server-side receiver for the multisim CPU data channel. Starts the
//   multisim server, then polls it for 64-bit words sent by a remote CPU
//   client and buffers them in a DEPTH-entry FIFO. The words are presented
//   to the local DUT on a valid/ready interface. A word is only requested
//   from the server when a FIFO slot is free, so the client's back-pressure
//   follows this block's occupancy.
//
//   Parameters:
//     SERVER_NAME  name handed to the server start call (one per channel)
//     DEPTH        FIFO entries, power of two, >= 2
//   Ports:
//     clk             rising-edge clock
//     rst             asynchronous active-high reset
//     data_vld        head-of-FIFO word valid (fifo_count != 0)
//     data_rdy        DUT accepts the head word
//     data            head-of-FIFO word
//     server_running  server start handshake completed
//     fifo_count      occupancy, 0..DEPTH
//     rx_total        (CPU_MULTISIM_SERVER_STATS_EN) words pushed, wraps
//     full_cycles     (CPU_MULTISIM_SERVER_STATS_EN) RUN edges seen full
//
//   Optional feature macro: CPU_MULTISIM_SERVER_STATS_EN.
//
//   cpu_multisim_server_pkg carries the server call layer with the same
//   call signatures as the multisim server library, backed by an
//   in-simulator word store that the environment loads.

package cpu_multisim_server_pkg;

  localparam int unsigned SRV_WORDS = 64;

  logic [63:0] srv_mem [SRV_WORDS];
  int unsigned srv_len;
  int unsigned srv_rd;
  int unsigned srv_start_fail;
  int unsigned srv_start_calls;
  int unsigned srv_get_calls;
  int unsigned srv_get_hits;
  string       srv_last_name;

  // Returns 1 once the server listens; the first srv_start_fail calls fail.
  function automatic int multisim_server_start(input string name);
    srv_start_calls++;
    srv_last_name = name;
    return (srv_start_calls > srv_start_fail) ? 1 : 0;
  endfunction

  function automatic int multisim_server_get_data(output logic [63:0] data);
    srv_get_calls++;
    if (srv_rd < srv_len) begin
      data = srv_mem[srv_rd[5:0]];
      srv_rd++;
      srv_get_hits++;
      return 1;
    end
    data = '0;
    return 0;
  endfunction

  function automatic void srv_push_word(input logic [63:0] w);
    if (srv_len < SRV_WORDS) begin
      srv_mem[srv_len[5:0]] = w;
      srv_len++;
    end
  endfunction

  function automatic void srv_set_start_fail(input int unsigned n);
    srv_start_fail = n;
  endfunction

  function automatic int unsigned srv_start_call_count();
    return srv_start_calls;
  endfunction

  function automatic int unsigned srv_get_call_count();
    return srv_get_calls;
  endfunction

  function automatic int unsigned srv_get_hit_count();
    return srv_get_hits;
  endfunction

  function automatic string srv_name();
    return srv_last_name;
  endfunction

endpackage

module cpu_multisim_server_rx
  import cpu_multisim_server_pkg::*;
#(
  parameter string       SERVER_NAME = "cpu_0",
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     data_vld,
  input  logic                     data_rdy,
  output logic [63:0]              data,
  output logic                     server_running,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef CPU_MULTISIM_SERVER_STATS_EN
  ,
  output logic [31:0]              rx_total,
  output logic [31:0]              full_cycles
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [0:0] {START, RUN} state_t;

`ifdef CPU_MULTISIM_SERVER_STATS_EN
  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [PW-1:0] wp;
    logic [63:0]   word;
    logic [31:0]   total;
  } step_t;
`else
  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [PW-1:0] wp;
    logic [63:0]   word;
  } step_t;
`endif

  state_t        state;
  logic [63:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  assign data_vld = (fifo_count != '0);
  assign data     = mem[rd_ptr];
  assign pop      = data_vld && data_rdy;

  // The server poll has side effects and must run exactly once per edge,
  // so its result and every state it affects are folded into one returned
  // record that the clocked block assigns in a single non-blocking update.
  function automatic step_t poll_step(input logic pop_i);
    step_t       s;
    logic [63:0] w;
    int          rc;
    rc     = multisim_server_get_data(w);
    s.cnt  = fifo_count - CW'(pop_i);
    s.wp   = wr_ptr;
    s.word = mem[wr_ptr];
`ifdef CPU_MULTISIM_SERVER_STATS_EN
    s.total = rx_total;
`endif
    if (rc == 1) begin
      s.cnt  = s.cnt + CW'(1);
      s.wp   = wr_ptr + PW'(1);
      s.word = w;
`ifdef CPU_MULTISIM_SERVER_STATS_EN
      s.total = rx_total + 32'd1;
`endif
    end
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= START;
      server_running <= 1'b0;
      fifo_count     <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef CPU_MULTISIM_SERVER_STATS_EN
      rx_total       <= '0;
`endif
    end else begin
      case (state)
        START: begin
          if (multisim_server_start(SERVER_NAME) == 1) begin
            state          <= RUN;
            server_running <= 1'b1;
          end
        end
        RUN: begin
          if (pop) rd_ptr <= rd_ptr + PW'(1);
          // Poll decision uses the pre-edge count: a full FIFO skips the
          // call even when the head is being popped on this edge.
          if (fifo_count != FULL) begin
`ifdef CPU_MULTISIM_SERVER_STATS_EN
            {fifo_count, wr_ptr, mem[wr_ptr], rx_total} <= poll_step(pop);
`else
            {fifo_count, wr_ptr, mem[wr_ptr]} <= poll_step(pop);
`endif
          end else if (pop) begin
            fifo_count <= fifo_count - CW'(1);
          end
        end
      endcase
    end
  end

`ifdef CPU_MULTISIM_SERVER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cycles <= '0;
    end else if (state == RUN && fifo_count == FULL) begin
      full_cycles <= full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_multisim_server_rx.sv
`timescale 1ns/1ps
module tb_cpu_multisim_server_rx;
  import cpu_multisim_server_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_vld;
  logic        data_rdy = 1'b0;
  logic [63:0] data;
  logic        server_running;
  logic [2:0]  fifo_count;
`ifdef CPU_MULTISIM_SERVER_STATS_EN
  logic [31:0] rx_total;
  logic [31:0] full_cycles;
`endif

  cpu_multisim_server_rx #(
    .SERVER_NAME("cpu_0"),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_vld(data_vld),
    .data_rdy(data_rdy),
    .data(data),
    .server_running(server_running),
    .fifo_count(fifo_count)
`ifdef CPU_MULTISIM_SERVER_STATS_EN
    ,
    .rx_total(rx_total),
    .full_cycles(full_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        vld;
    int unsigned cnt;
    logic [63:0] data;
    int          calls;   // get_data calls since segment start, -1 = skip
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic vld, input int unsigned cnt,
                     input logic [63:0] d, input int calls);
    vec_t v;
    v.rdy = rdy; v.vld = vld; v.cnt = cnt; v.data = d; v.calls = calls;
    vecs.push_back(v);
  endtask

  // Called at a negedge; each row drives data_rdy, takes one rising edge
  // and checks the outputs at the following negedge.
  task automatic run_rows(input int first, input int last, input string tag);
    int unsigned base;
    base = srv_get_call_count();
    for (int i = first; i <= last; i++) begin
      data_rdy = vecs[i].rdy;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s[%0d].vld", tag, i - first), 64'(data_vld), 64'(vecs[i].vld));
      check($sformatf("%s[%0d].cnt", tag, i - first), 64'(fifo_count), 64'(vecs[i].cnt));
      if (vecs[i].vld)
        check($sformatf("%s[%0d].data", tag, i - first), data, vecs[i].data);
      if (vecs[i].calls >= 0)
        check($sformatf("%s[%0d].calls", tag, i - first),
              64'(srv_get_call_count() - base), 64'(vecs[i].calls));
    end
  endtask

  function automatic logic [63:0] wa(input int j);
    return 64'hC0DE_0000_0000_00A0 + 64'(j);
  endfunction
  function automatic logic [63:0] wb(input int j);
    return 64'hBEEF_0000_0000_00B0 + 64'(j);
  endfunction
  function automatic logic [63:0] wc(input int j);
    return 64'hFACE_0000_0000_00C0 + 64'(j);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_first, s_last, c_first, c_last, dpre_first, dpre_last;
    int dpost_first, dpost_last, f_first, f_last;
    int unsigned calls0, starts0, hits0;

    // Streaming: words 1..16, one per cycle, count never above 1.
    s_first = vecs.size();
    for (int k = 1; k <= 16; k++) add(1'b1, 1'b1, 1, 64'(k), k);
    add(1'b1, 1'b0, 0, '0, 17);
    s_last = vecs.size() - 1;

    // Back-pressure, full with one-cycle pop pulse, then drain.
    c_first = vecs.size();
    for (int j = 1; j <= 20; j++) add(1'b0, 1'b1, (j < 4) ? j : 4, wa(0), (j < 4) ? j : 4);
    add(1'b1, 1'b1, 3, wa(1), 4);
    add(1'b0, 1'b1, 4, wa(1), 5);
    add(1'b1, 1'b1, 3, wa(2), 5);
    add(1'b1, 1'b1, 3, wa(3), 6);
    add(1'b1, 1'b1, 3, wa(4), 7);
    add(1'b1, 1'b1, 3, wa(5), 8);
    add(1'b1, 1'b1, 3, wa(6), 9);
    add(1'b1, 1'b1, 3, wa(7), 10);
    add(1'b1, 1'b1, 2, wa(8), 11);
    add(1'b1, 1'b1, 1, wa(9), 12);
    add(1'b1, 1'b0, 0, '0, 13);
    c_last = vecs.size() - 1;

    // Reset mid-stream: three buffered, then three delivered after restart.
    dpre_first = vecs.size();
    add(1'b0, 1'b1, 1, wb(0), 1);
    add(1'b0, 1'b1, 2, wb(0), 2);
    add(1'b0, 1'b1, 3, wb(0), 3);
    dpre_last = vecs.size() - 1;
    dpost_first = vecs.size();
    add(1'b1, 1'b1, 1, wb(3), 1);
    add(1'b1, 1'b1, 1, wb(4), 2);
    add(1'b1, 1'b1, 1, wb(5), 3);
    add(1'b1, 1'b0, 0, '0, 4);
    dpost_last = vecs.size() - 1;

    // Six words, five edges spent full.
    f_first = vecs.size();
    add(1'b0, 1'b1, 1, wc(0), 1);
    add(1'b0, 1'b1, 2, wc(0), 2);
    add(1'b0, 1'b1, 3, wc(0), 3);
    for (int j = 0; j < 5; j++) add(1'b0, 1'b1, 4, wc(0), 4);
    add(1'b1, 1'b1, 3, wc(1), 4);
    add(1'b1, 1'b1, 3, wc(2), 5);
    add(1'b1, 1'b1, 3, wc(3), 6);
    add(1'b1, 1'b1, 2, wc(4), 7);
    add(1'b1, 1'b1, 1, wc(5), 8);
    add(1'b1, 1'b0, 0, '0, 9);
    f_last = vecs.size() - 1;

    // Reset state and start retry (three refused starts).
    srv_set_start_fail(3);
    @(negedge clk);
    @(negedge clk);
    check("rst.vld", 64'(data_vld), 64'd0);
    check("rst.data", data, 64'd0);
    check("rst.cnt", 64'(fifo_count), 64'd0);
    check("rst.running", 64'(server_running), 64'd0);
    check("rst.start_calls", 64'(srv_start_call_count()), 64'd0);
    check("rst.get_calls", 64'(srv_get_call_count()), 64'd0);
`ifdef CPU_MULTISIM_SERVER_STATS_EN
    check("rst.rx_total", 64'(rx_total), 64'd0);
    check("rst.full_cycles", 64'(full_cycles), 64'd0);
`endif
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("start3.running", 64'(server_running), 64'd0);
    check("start3.start_calls", 64'(srv_start_call_count()), 64'd3);
    @(negedge clk);
    check("start4.running", 64'(server_running), 64'd1);
    check("start4.start_calls", 64'(srv_start_call_count()), 64'd4);
    check("start4.get_calls", 64'(srv_get_call_count()), 64'd0);
    n_checks++;
    if (srv_name() != "cpu_0") begin
      n_fail++;
      $display("FAIL start.name: got %s, expected cpu_0", srv_name());
    end
    @(negedge clk);
    check("edge5.get_calls", 64'(srv_get_call_count()), 64'd1);
    check("edge5.hits", 64'(srv_get_hit_count()), 64'd0);
    check("edge5.vld", 64'(data_vld), 64'd0);

    for (int k = 1; k <= 16; k++) srv_push_word(64'(k));
    run_rows(s_first, s_last, "stream");

    hits0 = srv_get_hit_count();
    for (int j = 0; j < 10; j++) srv_push_word(wa(j));
    run_rows(c_first, c_first + 19, "bp");
    check("bp.hits_full", 64'(srv_get_hit_count() - hits0), 64'd4);
    // rows after the fill keep counting calls from the segment start
    begin
      int unsigned base_adj;
      base_adj = srv_get_call_count() - 4;
      for (int i = c_first + 20; i <= c_last; i++) begin
        data_rdy = vecs[i].rdy;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("bp[%0d].vld", i - c_first), 64'(data_vld), 64'(vecs[i].vld));
        check($sformatf("bp[%0d].cnt", i - c_first), 64'(fifo_count), 64'(vecs[i].cnt));
        if (vecs[i].vld)
          check($sformatf("bp[%0d].data", i - c_first), data, vecs[i].data);
        check($sformatf("bp[%0d].calls", i - c_first),
              64'(srv_get_call_count() - base_adj), 64'(vecs[i].calls));
      end
    end
    check("bp.hits_total", 64'(srv_get_hit_count() - hits0), 64'd10);

    // Reset mid-stream.
    for (int j = 0; j < 6; j++) srv_push_word(wb(j));
    run_rows(dpre_first, dpre_last, "rpre");
`ifdef CPU_MULTISIM_SERVER_STATS_EN
    check("rpre.rx_total", 64'(rx_total), 64'd29);
    check("rpre.full_cycles", 64'(full_cycles), 64'd18);
`endif
    #2 rst = 1'b1;
    #1;
    check("rmid.vld", 64'(data_vld), 64'd0);
    check("rmid.data", data, 64'd0);
    check("rmid.cnt", 64'(fifo_count), 64'd0);
    check("rmid.running", 64'(server_running), 64'd0);
`ifdef CPU_MULTISIM_SERVER_STATS_EN
    check("rmid.rx_total", 64'(rx_total), 64'd0);
    check("rmid.full_cycles", 64'(full_cycles), 64'd0);
`endif
    calls0  = srv_get_call_count();
    starts0 = srv_start_call_count();
    repeat (2) @(negedge clk);
    check("rhold.get_calls", 64'(srv_get_call_count() - calls0), 64'd0);
    check("rhold.start_calls", 64'(srv_start_call_count() - starts0), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstart.running", 64'(server_running), 64'd1);
    check("rstart.start_calls", 64'(srv_start_call_count() - starts0), 64'd1);
    check("rstart.get_calls", 64'(srv_get_call_count() - calls0), 64'd0);
    run_rows(dpost_first, dpost_last, "rpost");
`ifdef CPU_MULTISIM_SERVER_STATS_EN
    check("rpost.rx_total", 64'(rx_total), 64'd3);
    check("rpost.full_cycles", 64'(full_cycles), 64'd0);
`endif

    // Fresh reset, then the full-cycle scenario.
    data_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("fstart.running", 64'(server_running), 64'd1);
    for (int j = 0; j < 6; j++) srv_push_word(wc(j));
    run_rows(f_first, f_last, "full");
`ifdef CPU_MULTISIM_SERVER_STATS_EN
    check("full.rx_total", 64'(rx_total), 64'd6);
    check("full.full_cycles", 64'(full_cycles), 64'd5);
    rst = 1'b1;
    #1;
    check("full.rx_total_rst", 64'(rx_total), 64'd0);
    check("full.full_cycles_rst", 64'(full_cycles), 64'd0);
    @(negedge clk);
    rst = 1'b0;
`endif
    check("end.hits", 64'(srv_get_hit_count()), 64'd38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
